// File: rtl/bitsync_pkg.sv
// Shared definitions for the QPSK bit-synchroniser loop controller:
// FSM state encoding and default loop parameters.
package bitsync_pkg;

  localparam int K_WIDTH_DEF  = 4;
  localparam int K_THRESH_DEF = 4;
  localparam int SETTLE_N_DEF = 2;
  localparam int LOCK_WIN_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILTER  = 3'd1,
    ST_ADVANCE = 3'd2,
    ST_RETARD  = 3'd3,
    ST_SETTLE  = 3'd4
  } state_t;

endpackage

// File: rtl/bitsync_rw_filter.sv
// Signed random-walk filter: integrates early/late strobes and flags when the
// next value reaches +/-K_THRESH. On overflow or clear the count returns to 0.
module bitsync_rw_filter
  import bitsync_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int K_THRESH = K_THRESH_DEF
) (
  input  logic clk32,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic up,
  input  logic down,
  output logic ovf_pos,
  output logic ovf_neg
);

  localparam logic signed [K_WIDTH-1:0] THR_POS = K_WIDTH'(K_THRESH);
  localparam logic signed [K_WIDTH-1:0] THR_NEG = -THR_POS;
  localparam logic signed [K_WIDTH-1:0] ONE     = K_WIDTH'(1);

  logic signed [K_WIDTH-1:0] value_q;
  logic signed [K_WIDTH-1:0] sum;

  // Threshold sits inside the signed range, so the count overflows before it can wrap.
  always_comb begin
    sum = value_q;
    if (en && up && !down)      sum = value_q + ONE;
    else if (en && down && !up) sum = value_q - ONE;
  end

  assign ovf_pos = en && (sum == THR_POS);
  assign ovf_neg = en && (sum == THR_NEG);

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n)                           value_q <= '0;
    else if (clear || ovf_pos || ovf_neg) value_q <= '0;
    else                                  value_q <= sum;
  end

endmodule

// File: rtl/bitsync_loop_ctrl.sv
// Digital-PLL loop controller: random-walk filter, one-shot divider correction,
// settle window and lock detect. Optional correction counters: BITSYNC_CORR_STATS_EN.
module bitsync_loop_ctrl
  import bitsync_pkg::*;
#(
  parameter int K_WIDTH  = K_WIDTH_DEF,
  parameter int K_THRESH = K_THRESH_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF,
  parameter int LOCK_WIN = LOCK_WIN_DEF
) (
  input  logic        clk32,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        early,
  input  logic        late,
  input  logic        clk_d1,
  input  logic        clk_d2,
  output logic        pd_before,
  output logic        pd_after,
  output logic        lock,
  output logic [15:0] adv_cnt,
  output logic [15:0] ret_cnt,
  output state_t      dbg_state
);

  localparam int LOCK_W   = $clog2(LOCK_WIN + 1);
  localparam int SETTLE_W = $clog2(SETTLE_N + 1);

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                ovf_pos, ovf_neg, filt_en, adv_done, ret_done;

  assign filt_en = enable && (state_q == ST_FILTER);

  bitsync_rw_filter #(.K_WIDTH(K_WIDTH), .K_THRESH(K_THRESH)) u_filter (
    .clk32   (clk32),
    .rst_n   (rst_n),
    .clear   (!filt_en),
    .en      (filt_en),
    .up      (early),
    .down    (late),
    .ovf_pos (ovf_pos),
    .ovf_neg (ovf_neg)
  );

  // Request handshake: pd_after/pd_before is held high until the divider's matching
  // enable (clk_d2/clk_d1) is seen with it; that cycle is the consume, dropped next cycle.
  assign adv_done = pd_after && clk_d2;
  assign ret_done = pd_before && clk_d1;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_FILTER;
      ST_FILTER: begin
        if (clk_d1 && (lock_cnt_q != LOCK_W'(LOCK_WIN))) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        if (ovf_pos) begin
          state_d    = ST_ADVANCE;
          lock_cnt_d = '0;
        end else if (ovf_neg) begin
          state_d    = ST_RETARD;
          lock_cnt_d = '0;
        end
      end
      ST_ADVANCE: if (adv_done) begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_RETARD: if (ret_done) begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: if (clk_d1) begin
        if (settle_q == SETTLE_W'(SETTLE_N - 1)) state_d = ST_FILTER;
        else                                     settle_d = settle_q + SETTLE_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d    = ST_IDLE;
      settle_d   = '0;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Outputs decoded from the next state so the request rises on the first ADVANCE/RETARD cycle.
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      pd_before <= 1'b0;
      pd_after  <= 1'b0;
      lock      <= 1'b0;
    end else begin
      pd_before <= (state_d == ST_RETARD);
      pd_after  <= (state_d == ST_ADVANCE);
      lock      <= (lock_cnt_d == LOCK_W'(LOCK_WIN));
    end
  end

  assign dbg_state = state_q;

`ifdef BITSYNC_CORR_STATS_EN
  logic [15:0] adv_q, ret_q;

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      adv_q <= '0;
      ret_q <= '0;
    end else begin
      if (adv_done && (adv_q != 16'hFFFF)) adv_q <= adv_q + 16'd1;
      if (ret_done && (ret_q != 16'hFFFF)) ret_q <= ret_q + 16'd1;
    end
  end

  assign adv_cnt = adv_q;
  assign ret_cnt = ret_q;
`else
  assign adv_cnt = 16'h0000;
  assign ret_cnt = 16'h0000;
`endif

endmodule
